store_buffer_fwd: RTL

Parametrised two-stage store buffer for the LSU store path, sitting between the store unit and the D$ write port. A speculative queue holds translated stores until the commit stage retires them; a commit queue drains them to memory with a bounded number of outstanding writes. Beyond draining, the block forwards data to loads from the youngest fully-covering doubleword entry. It flags page-offset conflicts so the load unit stalls only when forwarding is impossible.

---
 rtl/store_buffer_fwd_pkg.sv | 24 ++
 rtl/store_buffer_fwd_sb_queue.sv | 75 +++++++
 rtl/store_buffer_fwd.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_fwd_pkg.sv
// Shared constants and byte-enable helpers for the LSU store buffer.
package store_buffer_fwd_pkg;

  localparam int unsigned SB_DEPTH_SPEC   = 4;
  localparam int unsigned SB_DEPTH_COMMIT = 4;
  localparam int unsigned SB_MAX_OUTST    = 2;
  localparam int unsigned SB_DATA_W       = 64;
  localparam int unsigned SB_BE_W         = 8;
  localparam int unsigned SB_SIZE_W       = 2;
  // Doubleword tag starts at bit 3; page offset ends at bit 11.
  localparam int unsigned SB_DW_LSB       = 3;
  localparam int unsigned SB_PAGE_LSB     = 12;

  function automatic logic be_overlaps(input logic [SB_BE_W-1:0] st_be,
                                       input logic [SB_BE_W-1:0] ld_be);
    return |(st_be & ld_be);
  endfunction

  function automatic logic be_covers(input logic [SB_BE_W-1:0] st_be,
                                     input logic [SB_BE_W-1:0] ld_be);
    return (st_be & ld_be) == ld_be;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_sb_queue.sv
// Circular FIFO exposing every entry, its valid bits, pointers and count.
module sb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            push_i,
  input  logic [WIDTH-1:0]                wdata_i,
  input  logic                            pop_i,
  output logic [DEPTH-1:0][WIDTH-1:0]     entries_o,
  output logic [DEPTH-1:0]                valid_o,
  output logic [$clog2(DEPTH)-1:0]        rptr_o,
  output logic [$clog2(DEPTH)-1:0]        wptr_o,
  output logic [$clog2(DEPTH):0]          cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [PTR_W-1:0]            rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Pop is applied before flush so a same-cycle retire survives the flush.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    if (pop_i) begin
      mem_d[rptr_q]   = '0;
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PTR_W'(1);
    end
    if (flush_i) begin
      valid_d = '0;
      wptr_d  = rptr_d;
      cnt_d   = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q]   = wdata_i;
        valid_d[wptr_q] = 1'b1;
        wptr_d          = wptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      valid_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign entries_o = mem_q;
  assign valid_o   = valid_q;
  assign rptr_o    = rptr_q;
  assign wptr_o    = wptr_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/store_buffer_fwd.sv
// Two-stage store buffer (speculative + commit queue) with store-to-load forwarding.
module store_buffer_fwd
  import store_buffer_fwd_pkg::*;
#(
  parameter int unsigned DEPTH_SPEC   = SB_DEPTH_SPEC,
  parameter int unsigned DEPTH_COMMIT = SB_DEPTH_COMMIT,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned MAX_OUTST    = SB_MAX_OUTST
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  no_st_pending_o,
  input  logic                  valid_i,
  output logic                  spec_ready_o,
  input  logic [ADDR_W-1:0]     paddr_i,
  input  logic [SB_DATA_W-1:0]  data_i,
  input  logic [SB_BE_W-1:0]    be_i,
  input  logic [SB_SIZE_W-1:0]  size_i,
  input  logic                  commit_i,
  output logic                  commit_ready_o,
  input  logic                  ld_valid_i,
  input  logic [ADDR_W-1:0]     ld_paddr_i,
  input  logic [SB_BE_W-1:0]    ld_be_i,
  output logic                  fwd_hit_o,
  output logic [SB_DATA_W-1:0]  fwd_data_o,
  output logic                  offset_match_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [SB_DATA_W-1:0]  mem_wdata_o,
  output logic [SB_BE_W-1:0]    mem_be_o,
  output logic [SB_SIZE_W-1:0]  mem_size_o,
  input  logic                  mem_rvalid_i
);

  localparam int unsigned SP_W  = $clog2(DEPTH_SPEC);
  localparam int unsigned CM_W  = $clog2(DEPTH_COMMIT);
  localparam int unsigned SC_W  = SP_W + 1;
  localparam int unsigned CC_W  = CM_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   be;
    logic [SB_SIZE_W-1:0] size;
  } sb_entry_t;

  localparam int unsigned ENTRY_W = $bits(sb_entry_t);

  sb_entry_t                   push_entry;
  sb_entry_t [DEPTH_SPEC-1:0]  spec_mem;
  sb_entry_t [DEPTH_COMMIT-1:0] cm_mem;
  logic [DEPTH_SPEC-1:0]       spec_valid;
  logic [DEPTH_COMMIT-1:0]     cm_valid;
  logic [SP_W-1:0]             spec_rptr, spec_wptr, fwd_si;
  logic [CM_W-1:0]             cm_rptr, cm_wptr, fwd_ci;
  logic [SC_W-1:0]             spec_cnt;
  logic [CC_W-1:0]             cm_cnt;
  logic                        spec_push, mem_fire;
  logic [OUT_W-1:0]            outst_q, outst_d;
  logic                        fwd_found, fwd_push, fwd_off;
  logic [SB_BE_W-1:0]          fwd_be;
  logic [SB_DATA_W-1:0]        fwd_data;
  logic                        unused_ld_lsb;

  assign spec_push  = valid_i && !flush_i;
  assign push_entry = '{addr: paddr_i, data: data_i, be: be_i, size: size_i};

  sb_queue #(.DEPTH(DEPTH_SPEC), .WIDTH(ENTRY_W)) i_spec_q (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .push_i    (spec_push),
    .wdata_i   (push_entry),
    .pop_i     (commit_i),
    .entries_o (spec_mem),
    .valid_o   (spec_valid),
    .rptr_o    (spec_rptr),
    .wptr_o    (spec_wptr),
    .cnt_o     (spec_cnt)
  );

  sb_queue #(.DEPTH(DEPTH_COMMIT), .WIDTH(ENTRY_W)) i_commit_q (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (1'b0),
    .push_i    (commit_i),
    .wdata_i   (spec_mem[spec_rptr]),
    .pop_i     (mem_fire),
    .entries_o (cm_mem),
    .valid_o   (cm_valid),
    .rptr_o    (cm_rptr),
    .wptr_o    (cm_wptr),
    .cnt_o     (cm_cnt)
  );

  assign spec_ready_o    = spec_cnt < SC_W'(DEPTH_SPEC);
  assign commit_ready_o  = cm_cnt < CC_W'(DEPTH_COMMIT);
  assign no_st_pending_o = (cm_cnt == '0) && (outst_q == '0);

  assign mem_req_o   = cm_valid[cm_rptr] && (outst_q < OUT_W'(MAX_OUTST));
  assign mem_fire    = mem_req_o && mem_gnt_i;
  assign mem_addr_o  = cm_mem[cm_rptr].addr;
  assign mem_wdata_o = cm_mem[cm_rptr].data;
  assign mem_be_o    = cm_mem[cm_rptr].be;
  assign mem_size_o  = cm_mem[cm_rptr].size;

  always_comb begin
    outst_d = outst_q;
    case ({mem_fire, mem_rvalid_i})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outst_q <= '0;
    else         outst_q <= outst_d;
  end

  function automatic logic dw_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:SB_DW_LSB] == b[ADDR_W-1:SB_DW_LSB];
  endfunction

  function automatic logic off_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[SB_PAGE_LSB-1:SB_DW_LSB] == b[SB_PAGE_LSB-1:SB_DW_LSB];
  endfunction

  // Youngest-first search: in-flight push, then spec newest->oldest, then commit newest->oldest.
  always_comb begin
    fwd_found = 1'b0;
    fwd_push  = 1'b0;
    fwd_off   = 1'b0;
    fwd_be    = '0;
    fwd_data  = '0;
    fwd_si    = '0;
    fwd_ci    = '0;
    if (ld_valid_i) begin
      if (spec_push) begin
        if (dw_eq(paddr_i, ld_paddr_i) && be_overlaps(be_i, ld_be_i)) begin
          fwd_found = 1'b1;
          fwd_push  = 1'b1;
          fwd_be    = be_i;
        end
        if (off_eq(paddr_i, ld_paddr_i)) fwd_off = 1'b1;
      end
      for (int unsigned i = 0; i < DEPTH_SPEC; i++) begin
        fwd_si = spec_wptr - SP_W'(i + 1);
        if (spec_valid[fwd_si]) begin
          if (!fwd_found && dw_eq(spec_mem[fwd_si].addr, ld_paddr_i)
              && be_overlaps(spec_mem[fwd_si].be, ld_be_i)) begin
            fwd_found = 1'b1;
            fwd_be    = spec_mem[fwd_si].be;
            fwd_data  = spec_mem[fwd_si].data;
          end
          if (off_eq(spec_mem[fwd_si].addr, ld_paddr_i)) fwd_off = 1'b1;
        end
      end
      for (int unsigned i = 0; i < DEPTH_COMMIT; i++) begin
        fwd_ci = cm_wptr - CM_W'(i + 1);
        if (cm_valid[fwd_ci]) begin
          if (!fwd_found && dw_eq(cm_mem[fwd_ci].addr, ld_paddr_i)
              && be_overlaps(cm_mem[fwd_ci].be, ld_be_i)) begin
            fwd_found = 1'b1;
            fwd_be    = cm_mem[fwd_ci].be;
            fwd_data  = cm_mem[fwd_ci].data;
          end
          if (off_eq(cm_mem[fwd_ci].addr, ld_paddr_i)) fwd_off = 1'b1;
        end
      end
    end
  end

  assign fwd_hit_o      = fwd_found && !fwd_push && be_covers(fwd_be, ld_be_i);
  assign fwd_data_o     = fwd_hit_o ? fwd_data : '0;
  assign offset_match_o = !fwd_hit_o && fwd_off;
  assign unused_ld_lsb  = ^ld_paddr_i[SB_DW_LSB-1:0];

  a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    spec_push |-> spec_ready_o);
  a_commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> ((spec_cnt != '0) && commit_ready_o));
  a_rvalid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (outst_q != '0));

endmodule
